pc_unit: RTL and testbench

- Parametrised next-generation PC calculation unit for the RISC-V core.
- Holds the architectural PC register and computes the next PC from the branch type, ALU flags, immediate offset and JALR target.
- Adds a stall input, unsigned branch conditions and a return-address stack (RAS) that predicts return targets and flags mispredictions.
- Sits between the decoder/ALU and the instruction-memory address port.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_unit_if.sv | 33 +++
 rtl/pc_unit_ras_stack.sv | 50 +++++
 rtl/pc_unit.sv | 90 +++++++++
 tb/tb_pc_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC calculation unit and its return-address stack.
package pc_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    JAL  = 4'd1,
    JALR = 4'd2,
    BEQ  = 4'd3,
    BNE  = 4'd4,
    BLT  = 4'd5,
    BGE  = 4'd6,
    BLTU = 4'd7,
    BGEU = 4'd8
  } branch_type_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Decoder/ALU-facing bundle of the PC unit: control and operands in, PC and RAS status out.
interface pc_unit_if
  import pc_pkg::*;
#(
  parameter int XLEN = 32
);
  logic              stall;
  branch_type_e      branch_type;
  logic              alu_zero;
  logic              alu_neg;
  logic              alu_ltu;
  logic [XLEN-1:0]   pc_offset;
  logic [XLEN-1:0]   target_pc;
  logic              is_call;
  logic              is_ret;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   return_pc;
  logic              taken;
  logic [XLEN-1:0]   ras_top;
  logic              ras_valid;
  logic              ras_mispredict;
  logic              misaligned;

  modport master (
    output stall, branch_type, alu_zero, alu_neg, alu_ltu, pc_offset, target_pc, is_call, is_ret,
    input  pc, return_pc, taken, ras_top, ras_valid, ras_mispredict, misaligned
  );

  modport slave (
    input  stall, branch_type, alu_zero, alu_neg, alu_ltu, pc_offset, target_pc, is_call, is_ret,
    output pc, return_pc, taken, ras_top, ras_valid, ras_mispredict, misaligned
  );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry and
// the occupancy count saturates; push+pop together replaces the top entry.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            valid
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt;

  assign top_idx = ptr - PTR_W'(1);
  assign valid   = (cnt != '0);
  assign top     = valid ? mem[top_idx] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (push && pop) begin
      // An empty stack has no top to replace, so the replacement becomes a plain push.
      if (valid) begin
        mem[top_idx] <= din;
      end else begin
        mem[ptr] <= din;
        ptr      <= ptr + PTR_W'(1);
        cnt      <= CNT_W'(1);
      end
    end else if (push) begin
      mem[ptr] <= din;
      ptr      <= ptr + PTR_W'(1);
      if (cnt != CNT_W'(RAS_DEPTH)) cnt <= cnt + CNT_W'(1);
    end else if (pop && valid) begin
      ptr <= top_idx;
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Architectural PC register, next-PC selection and return-address prediction.
// Build option MISALIGN_TRAP_EN redirects misaligned taken targets to TRAP_VEC.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic     clk,
  input  logic     rstn,
  pc_unit_if.slave bus
);
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] return_pc;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            taken;
  logic            misaligned;
  logic            is_jal;
  logic            is_jalr;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_upd;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;

  assign is_jal      = (bus.branch_type == JAL);
  assign is_jalr     = (bus.branch_type == JALR);
  assign return_pc   = pc_q + XLEN'(INSTR_BYTES);
  assign br_target   = pc_q + bus.pc_offset;
  assign jalr_target = {bus.target_pc[XLEN-1:1], 1'b0};
  assign target      = is_jalr ? jalr_target : br_target;

  always_comb begin
    taken = 1'b0;
    case (bus.branch_type)
      JAL, JALR: taken = 1'b1;
      BEQ:       taken = bus.alu_zero;
      BNE:       taken = !bus.alu_zero;
      BLT:       taken = bus.alu_neg;
      BGE:       taken = !bus.alu_neg;
      BLTU:      taken = bus.alu_ltu;
      BGEU:      taken = !bus.alu_ltu;
      default:   taken = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = taken && (target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign next_pc = misaligned ? TRAP_VEC : (taken ? target : return_pc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= RESET_PC;
    else if (!bus.stall) pc_q <= next_pc;
  end

  // A trapping jump never commits, so it must not disturb the return stack.
  assign ras_upd  = !bus.stall && !misaligned;
  assign ras_push = ras_upd && (is_jal || is_jalr) && bus.is_call;
  assign ras_pop  = ras_upd && is_jalr && bus.is_ret;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (return_pc),
    .top   (ras_top),
    .valid (ras_valid)
  );

  assign bus.pc             = pc_q;
  assign bus.return_pc      = return_pc;
  assign bus.taken          = taken;
  assign bus.ras_top        = ras_top;
  assign bus.ras_valid      = ras_valid;
  assign bus.ras_mispredict = is_jalr && bus.is_ret && ras_valid && (ras_top != jalr_target);
  assign bus.misaligned     = misaligned;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a queue-based reference model checked every cycle, plus literal checkpoints.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(XLEN)) bus ();

  pc_unit #(
    .XLEN      (XLEN),
    .RESET_PC  (RESET_PC),
    .RAS_DEPTH (RAS_DEPTH),
    .TRAP_VEC  (TRAP_VEC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural PC plus the RAS as a queue (oldest at front, top at back).
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic [31:0] n_pc;
  logic [31:0] n_stack[$];
  bit          have_next;

  function automatic bit m_taken(input logic [3:0] bt, input bit z, input bit n, input bit ltu);
    if (bt == 4'(JAL) || bt == 4'(JALR)) return 1'b1;
    if (bt == 4'(BEQ))  return z;
    if (bt == 4'(BNE))  return !z;
    if (bt == 4'(BLT))  return n;
    if (bt == 4'(BGE))  return !n;
    if (bt == 4'(BLTU)) return ltu;
    if (bt == 4'(BGEU)) return !ltu;
    return 1'b0;
  endfunction

  initial begin
    logic [3:0]  bt;
    logic [31:0] tgt, rpc, top;
    bit          tk, mis, valid, jal, jalr;
    have_next = 0;
    forever begin
      @(negedge clk);
      have_next = 0;
      if (!rstn) begin
        m_pc = RESET_PC;
        m_stack.delete();
        chk("rst_pc", bus.pc, RESET_PC);
        chk("rst_ras_valid", 32'(bus.ras_valid), 32'd0);
        chk("rst_ras_top", bus.ras_top, 32'd0);
        chk("rst_return_pc", bus.return_pc, RESET_PC + 32'd4);
      end else begin
        bt    = bus.branch_type;
        jal   = (bt == 4'(JAL));
        jalr  = (bt == 4'(JALR));
        rpc   = m_pc + 32'd4;
        tk    = m_taken(bt, bus.alu_zero, bus.alu_neg, bus.alu_ltu);
        tgt   = jalr ? (bus.target_pc & ~32'd1) : (m_pc + bus.pc_offset);
`ifdef MISALIGN_TRAP_EN
        mis   = tk && (tgt % 4 != 0);
`else
        mis   = 1'b0;
`endif
        valid = (m_stack.size() > 0);
        top   = valid ? m_stack[m_stack.size()-1] : 32'd0;
        chk("pc", bus.pc, m_pc);
        chk("return_pc", bus.return_pc, rpc);
        chk("taken", 32'(bus.taken), 32'(tk));
        chk("ras_valid", 32'(bus.ras_valid), 32'(valid));
        chk("ras_top", bus.ras_top, top);
        chk("ras_mispredict", 32'(bus.ras_mispredict),
            32'(jalr && bus.is_ret && valid && (top != tgt)));
        chk("misaligned", 32'(bus.misaligned), 32'(mis));
        n_pc    = m_pc;
        n_stack = m_stack;
        if (!bus.stall) begin
          n_pc = mis ? TRAP_VEC : (tk ? tgt : rpc);
          if (!mis) begin
            if (jalr && bus.is_call && bus.is_ret) begin
              if (n_stack.size() > 0) n_stack[n_stack.size()-1] = rpc;
              else n_stack.push_back(rpc);
            end else if ((jal || jalr) && bus.is_call) begin
              n_stack.push_back(rpc);
              if (n_stack.size() > RAS_DEPTH) void'(n_stack.pop_front());
            end else if (jalr && bus.is_ret) begin
              if (n_stack.size() > 0) void'(n_stack.pop_back());
            end
          end
        end
        have_next = 1;
      end
      @(posedge clk);
      if (have_next && rstn) begin
        m_pc    = n_pc;
        m_stack = n_stack;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input branch_type_e bt, input bit z, input bit n, input bit ltu,
                       input logic [31:0] off, input logic [31:0] tgt,
                       input bit call, input bit ret, input bit stl);
    bus.branch_type = bt;
    bus.alu_zero    = z;
    bus.alu_neg     = n;
    bus.alu_ltu     = ltu;
    bus.pc_offset   = off;
    bus.target_pc   = tgt;
    bus.is_call     = call;
    bus.is_ret      = ret;
    bus.stall       = stl;
  endtask

  // Mid-run reset, then walk forward n sequential instructions (pc = 4*n).
  task automatic reset_walk(input int n);
    rstn = 1'b0;
    drive(NONE, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rstn = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    logic [31:0] pops [4];
    logic [31:0] held;
    pops = '{32'h24, 32'h1C, 32'h14, 32'hC};

    drive(NONE, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("lit_reset_pc", bus.pc, 32'h0);
    chk("lit_reset_valid", 32'(bus.ras_valid), 32'd0);
    rstn = 1'b1;
    repeat (3) tick();
    chk("lit_seq_pc12", bus.pc, 32'hC);
    chk("lit_seq_taken", 32'(bus.taken), 32'd0);
    tick();

    drive(BEQ, 1, 0, 0, 32'hC, 0, 0, 0, 0);
    #1 chk("lit_beq_taken", 32'(bus.taken), 32'd1);
    tick();
    chk("lit_beq_pc", bus.pc, 32'h1C);
    reset_walk(4);
    drive(BNE, 1, 0, 0, 32'hC, 0, 0, 0, 0);
    tick();
    chk("lit_bne_pc", bus.pc, 32'h14);
    reset_walk(4);
    drive(BLTU, 0, 0, 1, 32'hC, 0, 0, 0, 0);
    tick();
    chk("lit_bltu_pc", bus.pc, 32'h1C);
    reset_walk(4);
    drive(BGEU, 0, 0, 1, 32'hC, 0, 0, 0, 0);
    tick();
    chk("lit_bgeu_pc", bus.pc, 32'h14);

    reset_walk(4);
    drive(BLT, 0, 1, 0, 32'hFFFF_FFE0, 0, 0, 0, 0);
    tick();
    chk("lit_blt_wrap", bus.pc, 32'hFFFF_FFF0);
    drive(BGE, 0, 1, 0, 32'h8, 0, 0, 0, 0);
    tick();
    drive(branch_type_e'(4'd12), 0, 0, 0, 32'h40, 0, 0, 0, 0);
    repeat (3) tick();
    chk("lit_pc_wrap", bus.pc, 32'h0);

    held = bus.pc;
    drive(JALR, 0, 0, 0, 0, 32'hAD, 0, 0, 1);
    #1 chk("lit_jalr_taken", 32'(bus.taken), 32'd1);
    tick();
    chk("lit_stall_hold", bus.pc, held);
    bus.stall = 1'b0;
    tick();
    chk("lit_jalr_pc", bus.pc, 32'hAC);

    reset_walk(8);
    drive(JAL, 0, 0, 0, 32'h40, 0, 1, 0, 0);
    tick();
    chk("lit_call_top", bus.ras_top, 32'h24);
    drive(JALR, 0, 0, 0, 0, 32'h24, 0, 1, 0);
    #1 chk("lit_ret_ok", 32'(bus.ras_mispredict), 32'd0);
    tick();
    chk("lit_ret_pc", bus.pc, 32'h24);
    chk("lit_ret_empty", 32'(bus.ras_valid), 32'd0);

    reset_walk(8);
    drive(JAL, 0, 0, 0, 32'h40, 0, 1, 0, 0);
    tick();
    drive(JALR, 0, 0, 0, 0, 32'h30, 0, 1, 1);
    #1 chk("lit_mispredict_stall", 32'(bus.ras_mispredict), 32'd1);
    tick();
    bus.stall = 1'b0;
    tick();
    chk("lit_misp_pc", bus.pc, 32'h30);

    reset_walk(0);
    repeat (5) begin
      drive(JAL, 0, 0, 0, 32'h8, 0, 1, 0, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(JALR, 0, 0, 0, 0, pops[i], 0, 1, 0);
      #1 chk("lit_pop_top", bus.ras_top, pops[i]);
      tick();
    end
    chk("lit_pop_empty", 32'(bus.ras_valid), 32'd0);
    drive(JALR, 0, 0, 0, 0, 32'h40, 0, 1, 0);
    #1 chk("lit_pop5_nomisp", 32'(bus.ras_mispredict), 32'd0);
    tick();
    chk("lit_pop5_pc", bus.pc, 32'h40);

    drive(JALR, 0, 0, 0, 0, 32'h80, 1, 1, 0);
    tick();
    chk("lit_repl_empty_top", bus.ras_top, 32'h44);
    drive(JALR, 0, 0, 0, 0, 32'h100, 1, 1, 0);
    tick();
    chk("lit_repl_top", bus.ras_top, 32'h84);
    drive(JALR, 0, 0, 0, 0, 32'h84, 0, 1, 0);
    tick();
    chk("lit_repl_count1", 32'(bus.ras_valid), 32'd0);
    drive(BEQ, 0, 0, 0, 32'h10, 0, 1, 0, 0);
    tick();

    reset_walk(4);
    drive(BEQ, 1, 0, 0, 32'h6, 0, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
    #1 chk("lit_misalign", 32'(bus.misaligned), 32'd1);
    tick();
    chk("lit_misalign_pc", bus.pc, TRAP_VEC);
`else
    #1 chk("lit_misalign", 32'(bus.misaligned), 32'd0);
    tick();
    chk("lit_misalign_pc", bus.pc, 32'h16);
`endif
    drive(JAL, 0, 0, 0, 32'h2, 0, 1, 0, 0);
    tick();
    drive(NONE, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
